// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and default sizing.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_BITS     = 8;
  localparam int unsigned DEFAULT_PRESCALE = 4;

endpackage

// File: rtl/countdown_prescaler.sv
// Step-strobe divider for the countdown timer (used only when COUNTDOWN_PRESCALE_EN is defined).
// step fires on the PRESCALE-th un-held cycle after a clear; hold freezes the phase.
module countdown_prescaler
  import countdown_pkg::*;
#(
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic hold,
  output logic step
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign step = !hold && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/countdown_timer_n.sv
// Presettable down-counter/timer with IDLE/RUN/PAUSE/DONE FSM, one-shot or auto-reload, and tick.
// Define COUNTDOWN_PRESCALE_EN to decrement once every PRESCALE clocks instead of every clock.
module countdown_timer_n
  import countdown_pkg::*;
#(
  parameter int unsigned BITS     = DEFAULT_BITS,
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [BITS-1:0] load_val,
  input  logic            start,
  input  logic            pause,
  input  logic            auto_reload,
  output logic [BITS-1:0] q,
  output logic            tick,
  output logic            busy,
  output logic            done
);

  localparam logic [BITS-1:0] ONE = BITS'(1);

  if (PRESCALE == 0) begin : g_prescale_check
    $error("countdown_timer_n: PRESCALE must be >= 1");
  end

  state_t          state, state_n;
  logic [BITS-1:0] reload_reg, reload_n;
  logic [BITS-1:0] q_n;
  logic            tick_n;
  logic            step;

`ifdef COUNTDOWN_PRESCALE_EN
  logic pre_clear;
  logic pre_hold;

  // Counting edges are exactly those in RUN with neither load nor pause winning.
  assign pre_clear = load || (start && (state == ST_IDLE || state == ST_DONE));
  assign pre_hold  = (state != ST_RUN) || pause || load;

  countdown_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clear(pre_clear),
    .hold (pre_hold),
    .step (step)
  );
`else
  assign step = 1'b1;
`endif

  assign busy = (state == ST_RUN) || (state == ST_PAUSE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      q          <= '0;
      reload_reg <= '0;
      tick       <= 1'b0;
    end else begin
      state      <= state_n;
      q          <= q_n;
      reload_reg <= reload_n;
      tick       <= tick_n;
    end
  end

  always_comb begin
    state_n  = state;
    q_n      = q;
    reload_n = reload_reg;
    tick_n   = 1'b0;
    if (load) begin
      reload_n = load_val;
      q_n      = load_val;
      state_n  = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            q_n = reload_reg;
            if (reload_reg == '0) begin
              tick_n  = 1'b1;
              state_n = ST_DONE;
            end else begin
              state_n = ST_RUN;
            end
          end
        end
        ST_PAUSE: begin
          if (start) state_n = ST_RUN;
        end
        ST_RUN: begin
          if (pause) begin
            state_n = ST_PAUSE;
          end else if (step) begin
            // q is never 0 in RUN, so anything not above 1 is the terminal step.
            if (q > ONE) begin
              q_n = q - ONE;
            end else if (auto_reload) begin
              q_n    = reload_reg;
              tick_n = 1'b1;
            end else begin
              q_n     = '0;
              tick_n  = 1'b1;
              state_n = ST_DONE;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer_n.sv
// Directed self-checking bench for countdown_timer_n; expectations queued per step, checked after each edge.
module tb_countdown_timer_n;

  localparam int unsigned BITS = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            load = 1'b0;
  logic [BITS-1:0] load_val = '0;
  logic            start = 1'b0;
  logic            pause = 1'b0;
  logic            auto_reload = 1'b0;
  logic [BITS-1:0] q;
  logic            tick;
  logic            busy;
  logic            done;

  typedef struct {
    string           tag;
    logic [BITS-1:0] q;
    logic            tick;
    logic            busy;
    logic            done;
  } exp_t;

  exp_t sb[$];
  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  countdown_timer_n #(
    .BITS    (BITS),
    .PRESCALE(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_val   (load_val),
    .start      (start),
    .pause      (pause),
    .auto_reload(auto_reload),
    .q          (q),
    .tick       (tick),
    .busy       (busy),
    .done       (done)
  );

  task automatic check_all();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      assert (q === e.q) passed++;
      else $error("FAIL %s q observed=%0d expected=%0d", e.tag, q, e.q);
      total++;
      assert (tick === e.tick) passed++;
      else $error("FAIL %s tick observed=%b expected=%b", e.tag, tick, e.tick);
      total++;
      assert (busy === e.busy) passed++;
      else $error("FAIL %s busy observed=%b expected=%b", e.tag, busy, e.busy);
      total++;
      assert (done === e.done) passed++;
      else $error("FAIL %s done observed=%b expected=%b", e.tag, done, e.done);
    end
  endtask

  // Drive one edge's inputs, queue the state expected after that edge, then check.
  task automatic cyc(input string tag, input logic r, input logic l, input logic [BITS-1:0] lv,
                     input logic s, input logic p, input logic a,
                     input logic [BITS-1:0] eq, input logic et, input logic eb, input logic ed);
    exp_t e;
    rst = r; load = l; load_val = lv; start = s; pause = p; auto_reload = a;
    e.tag = tag; e.q = eq; e.tick = et; e.busy = eb; e.done = ed;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    #1;
    // Power-on reset, two cycles
    cyc("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // One-shot from 5
    cyc("os_load",  0, 1, 5, 0, 0, 0, 5, 0, 0, 0);
    cyc("os_start", 0, 0, 0, 1, 0, 0, 5, 0, 1, 0);
    for (int i = 4; i >= 1; i--)
      cyc("os_cnt", 0, 0, 0, 0, 0, 0, BITS'(i), 0, 1, 0);
    cyc("os_term",  0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    cyc("os_done1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("os_done2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Auto-reload from 3, ten steps
    cyc("ar_load",  0, 1, 3, 0, 0, 1, 3, 0, 0, 0);
    cyc("ar_start", 0, 0, 0, 1, 0, 1, 3, 0, 1, 0);
    for (int i = 1; i <= 10; i++)
      cyc("ar_step", 0, 0, 0, 0, 0, 1, BITS'(3 - (i % 3)), (i % 3) == 0, 1, 0);

    // Reset mid-count overrides a concurrent start
    cyc("mid_rst0", 1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    cyc("mid_rst1", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc("rst_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Pause/resume from 6
    cyc("pz_load",  0, 1, 6, 0, 0, 0, 6, 0, 0, 0);
    cyc("pz_start", 0, 0, 0, 1, 0, 0, 6, 0, 1, 0);
    cyc("pz_s1",    0, 0, 0, 0, 0, 0, 5, 0, 1, 0);
    cyc("pz_s2",    0, 0, 0, 0, 0, 0, 4, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      cyc("pz_hold", 0, 0, 0, 0, 1, 0, 4, 0, 1, 0);
    cyc("pz_resume", 0, 0, 0, 1, 0, 0, 4, 0, 1, 0);
    cyc("pz_r1",     0, 0, 0, 0, 0, 0, 3, 0, 1, 0);
    cyc("pz_r2",     0, 0, 0, 0, 0, 0, 2, 0, 1, 0);
    cyc("pz_r3",     0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    cyc("pz_term",   0, 0, 0, 0, 0, 0, 0, 1, 0, 1);

    // Zero-length timer
    cyc("z_load",  0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("z_start", 0, 0, 0, 1, 0, 0, 0, 1, 0, 1);
    cyc("z_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Load aborts a running count at q=2
    cyc("ab_load",  0, 1, 4, 0, 0, 0, 4, 0, 0, 0);
    cyc("ab_start", 0, 0, 0, 1, 0, 0, 4, 0, 1, 0);
    cyc("ab_s1",    0, 0, 0, 0, 0, 0, 3, 0, 1, 0);
    cyc("ab_s2",    0, 0, 0, 0, 0, 0, 2, 0, 1, 0);
    cyc("ab_abort", 0, 1, 9, 0, 0, 0, 9, 0, 0, 0);
    cyc("ab_after", 0, 0, 0, 0, 0, 0, 9, 0, 0, 0);

    // Load and start together: load wins, stays IDLE
    cyc("ls_both",  0, 1, 7, 1, 0, 0, 7, 0, 0, 0);
    cyc("ls_after", 0, 0, 0, 0, 0, 0, 7, 0, 0, 0);

    // start+pause in RUN pauses; start in RUN alone is ignored
    cyc("sp_start", 0, 0, 0, 1, 0, 0, 7, 0, 1, 0);
    cyc("sp_run",   0, 0, 0, 1, 0, 0, 6, 0, 1, 0);
    cyc("sp_both",  0, 0, 0, 1, 1, 0, 6, 0, 1, 0);
    cyc("sp_held",  0, 0, 0, 0, 0, 0, 6, 0, 1, 0);

    // Reload value 1 with auto-reload ticks on every step
    cyc("r1_load",  0, 1, 1, 0, 0, 1, 1, 0, 0, 0);
    cyc("r1_start", 0, 0, 0, 1, 0, 1, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      cyc("r1_tick", 0, 0, 0, 0, 0, 1, 1, 1, 1, 0);
    // Dropping auto_reload takes effect at the next terminal step
    cyc("r1_stop",  0, 0, 0, 0, 0, 0, 0, 1, 0, 1);

`ifdef COUNTDOWN_PRESCALE_EN
    // PRESCALE=4, preset 2: tick 8 cycles after start
    cyc("ps_load",  0, 1, 2, 0, 0, 0, 2, 0, 0, 0);
    cyc("ps_start", 0, 0, 0, 1, 0, 0, 2, 0, 1, 0);
    for (int j = 1; j <= 7; j++)
      cyc("ps_cnt", 0, 0, 0, 0, 0, 0, (j < 4) ? BITS'(2) : BITS'(1), 0, 1, 0);
    cyc("ps_term",  0, 0, 0, 0, 0, 0, 0, 1, 0, 1);

    // Pause freezes prescaler phase
    cyc("pp_load",  0, 1, 2, 0, 0, 0, 2, 0, 0, 0);
    cyc("pp_start", 0, 0, 0, 1, 0, 0, 2, 0, 1, 0);
    cyc("pp_c1",    0, 0, 0, 0, 0, 0, 2, 0, 1, 0);
    cyc("pp_c2",    0, 0, 0, 0, 0, 0, 2, 0, 1, 0);
    for (int j = 0; j < 3; j++)
      cyc("pp_hold", 0, 0, 0, 0, 1, 0, 2, 0, 1, 0);
    cyc("pp_resume", 0, 0, 0, 1, 0, 0, 2, 0, 1, 0);
    cyc("pp_r1",     0, 0, 0, 0, 0, 0, 2, 0, 1, 0);
    cyc("pp_r2",     0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    for (int j = 0; j < 3; j++)
      cyc("pp_cnt", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    cyc("pp_term",   0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
